// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and monitor FSM encoding.
// The transmitter (vga_top) and the receive-side monitor both import this.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // First visible column/row, counted from the sync assertion edge.
  localparam int H_VIS_START = H_SYNC + H_BACK;
  localparam int V_VIS_START = V_SYNC + V_BACK;

  localparam int SYNC_ACTIVE_LOW = 1;
  localparam int LOCK_FRAMES     = 2;

  localparam int CNT_W = 10;

  // Monitor FSM encoding; SEARCH is zero so the reset value is all-zero.
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_rx_axis_counter.sv
// One timing axis of the monitor: a saturating position counter plus
// period and pulse-width checks.
//
// count is the position of the sample currently in the input register:
// 0 on the restart cycle, otherwise the stored value advanced by enable.
// The period is the stored value + 1 on the restart cycle; the pulse width
// is count on the pulse_end cycle. viol is high only on those event cycles.
module vga_rx_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int PERIOD = 800,
  parameter int WIDTH  = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic             pulse_end,
  output logic [CNT_W-1:0] count,
  output logic             viol
);

  localparam logic [CNT_W:0]   PERIOD_L = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   WIDTH_L  = (CNT_W+1)'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   period_len;

  // Next position: restart wins, otherwise advance and stick at the top.
  always_comb begin
    count = cnt_q;
    if (restart) begin
      count = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      count = cnt_q + 1'b1;
    end
  end

  assign period_len = {1'b0, cnt_q} + 1'b1;

  // Period checked at restart, width checked at the pulse deassertion edge.
  always_comb begin
    viol = 1'b0;
    if (restart && (period_len != PERIOD_L)) begin
      viol = 1'b1;
    end
    if (pulse_end && ({1'b0, count} != WIDTH_L)) begin
      viol = 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= count;
    end
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: registers the incoming sync/colour pins,
// recovers pixel coordinates, checks line/frame timing and reports lock.
//
// pix_valid qualifies pix_x/pix_y/pix_rgb for exactly one cycle; there is
// no ready, the consumer must take every valid beat. When pix_valid is 0
// the pixel fields are forced to 0.
module vga_rx_monitor #(
  parameter int H_VISIBLE       = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT         = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC          = vga_timing_pkg::H_SYNC,
  parameter int H_BACK          = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE       = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT         = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC          = vga_timing_pkg::V_SYNC,
  parameter int V_BACK          = vga_timing_pkg::V_BACK,
  parameter int SYNC_ACTIVE_LOW = vga_timing_pkg::SYNC_ACTIVE_LOW,
  parameter int LOCK_FRAMES     = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       clk_25MHz,
  input  logic       d_reset,
  input  logic       Hsync,
  input  logic       Vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       locked,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [11:0] pix_rgb,
  output logic       frame_start,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [7:0] frame_count,
  output logic [1:0] dbg_state
);
  import vga_timing_pkg::*;

  localparam int LINE_LEN    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI = 10'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BACK + V_VISIBLE);

  logic        hs_in, vs_in;
  logic        hs_r, vs_r, hs_d, vs_d;
  logic [11:0] rgb_r;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic        vs_pend;
  logic [9:0]  h_pos, v_pos;
  logic        h_viol, v_viol, viol, vis;
  logic [1:0]  state_q, state_n;
  logic [7:0]  good_q, good_n;
  logic        lock_n;

  assign hs_in = (SYNC_ACTIVE_LOW != 0) ? ~Hsync : Hsync;
  assign vs_in = (SYNC_ACTIVE_LOW != 0) ? ~Vsync : Vsync;

  // Input register stage plus one-cycle history for edge detection.
  always_ff @(posedge clk_25MHz) begin
    if (d_reset) begin
      hs_r  <= 1'b0;
      vs_r  <= 1'b0;
      hs_d  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_r <= '0;
    end else begin
      hs_r  <= hs_in;
      vs_r  <= vs_in;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      rgb_r <= {red, green, blue};
    end
  end

  assign hs_rise = hs_r & ~hs_d;
  assign hs_fall = ~hs_r & hs_d;
  assign vs_rise = vs_r & ~vs_d;
  assign vs_fall = ~vs_r & vs_d;

  // Remember a Vsync assertion until the Hsync edge that restarts v_cnt.
  always_ff @(posedge clk_25MHz) begin
    if (d_reset || hs_rise) begin
      vs_pend <= 1'b0;
    end else if (vs_rise) begin
      vs_pend <= 1'b1;
    end
  end

  vga_rx_axis_counter #(.PERIOD(LINE_LEN), .WIDTH(H_SYNC)) u_h_axis (
    .clk       (clk_25MHz),
    .rst       (d_reset),
    .enable    (1'b1),
    .restart   (hs_rise),
    .pulse_end (hs_fall),
    .count     (h_pos),
    .viol      (h_viol)
  );

  vga_rx_axis_counter #(.PERIOD(FRAME_LINES), .WIDTH(V_SYNC)) u_v_axis (
    .clk       (clk_25MHz),
    .rst       (d_reset),
    .enable    (hs_rise),
    .restart   (hs_rise & (vs_pend | vs_rise)),
    .pulse_end (vs_fall),
    .count     (v_pos),
    .viol      (v_viol)
  );

  // Violations only matter once a Vsync edge has been seen.
  assign viol = (state_q != ST_SEARCH) && (h_viol || v_viol);
  assign vis  = (h_pos >= H_LO) && (h_pos < H_HI) && (v_pos >= V_LO) && (v_pos < V_HI);

  // Lock FSM: any violation drops straight back to SEARCH.
  always_comb begin
    state_n = state_q;
    good_n  = good_q;
    if (viol) begin
      state_n = ST_SEARCH;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (vs_rise) begin
            state_n = ST_ACQUIRE;
            good_n  = '0;
          end
        end
        ST_ACQUIRE: begin
          if (vs_rise) begin
            good_n = good_q + 8'd1;
            if (good_n >= 8'(LOCK_FRAMES)) begin
              state_n = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: ;
        default: state_n = ST_SEARCH;
      endcase
    end
  end

  assign lock_n    = (state_n == ST_LOCKED);
  assign dbg_state = state_q;

  // FSM state and all registered outputs.
  always_ff @(posedge clk_25MHz) begin
    if (d_reset) begin
      state_q     <= ST_SEARCH;
      good_q      <= '0;
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      state_q     <= state_n;
      good_q      <= good_n;
      locked      <= lock_n;
      pix_valid   <= vis && lock_n;
      pix_x       <= (vis && lock_n) ? h_pos - H_LO : '0;
      pix_y       <= (vis && lock_n) ? v_pos - V_LO : '0;
      pix_rgb     <= (vis && lock_n) ? rgb_r : '0;
      err_pulse   <= viol;
      frame_start <= vs_rise && lock_n;
      if (viol) begin
        err_count <= sat_inc8(err_count);
      end
      if (vs_rise && lock_n) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
